audio_conditioner: RTL and testbench

Audio post-processing stage between the game core's unsigned 16-bit `audio_out` and the `AUDIO_L`/`AUDIO_R` outputs of the top level. Once per output sample it applies a first-order low-pass filter, removes the DC offset to produce signed audio, and applies a click-free gain ramp. The ramp replaces the current hard zeroing of audio during pause. The block runs on `clk_sys` (40 MHz) and generates its own sample strobe.

---
 rtl/audio_conditioner.sv | 117 +++++++++++
 tb/tb_audio_conditioner.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/audio_conditioner.sv
`default_nettype none
// ============================================================================
// audio_conditioner : per-sample low-pass, DC removal and click-free gain ramp
// Revision 1.0
// ============================================================================
module audio_conditioner #(
  parameter int CE_DIV    = 833,
  parameter int LP_SHIFT  = 3,
  parameter int DC_SHIFT  = 10,
  parameter int RAMP_STEP = 1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [15:0] audio_in,
  input  logic        mute,
  output logic [15:0] audio_out,
  output logic        sample_ce,
  output logic        muted
);

  localparam int c_div_w = $clog2(CE_DIV);
  localparam int c_dc_w  = 16 + DC_SHIFT;
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CE_DIV - 1);
  localparam logic [8:0]         c_step     = 9'(RAMP_STEP);
  localparam logic signed [16:0] c_hp_max   = 17'sd32767;
  localparam logic signed [16:0] c_hp_min   = -17'sd32768;

  logic [c_div_w-1:0] r_div;
  logic               r_s1;
  logic               r_s2;
  logic [23:0]        r_lp_acc;
  logic [c_dc_w-1:0]  r_dc_acc;
  logic signed [15:0] r_hp_sat;
  logic [8:0]         r_gain;

  logic               w_s0;
  logic signed [25:0] w_lp_diff;
  logic signed [25:0] w_lp_step;
  logic signed [25:0] w_lp_sum;
  logic [15:0]        w_lp;
  logic [15:0]        w_dc_old;
  logic signed [16:0] w_hp;
  logic signed [15:0] w_hp_sat;
  logic [9:0]         w_gain_sum;
  logic [8:0]         w_gain_next;
  logic signed [24:0] w_prod;
  logic               w_unused;

  assign w_s0 = (r_div == c_div_last);

  // lp_acc carries 8 fractional bits; the 26-bit signed difference cannot overflow
  assign w_lp_diff = $signed({2'b00, audio_in, 8'h00}) - $signed({2'b00, r_lp_acc});
  assign w_lp_step = w_lp_diff >>> LP_SHIFT;
  assign w_lp_sum  = $signed({2'b00, r_lp_acc}) + w_lp_step;
  assign w_lp      = r_lp_acc[23:8];

  assign w_dc_old = r_dc_acc[c_dc_w-1:DC_SHIFT];
  assign w_hp     = $signed({1'b0, w_lp}) - $signed({1'b0, w_dc_old});

  always_comb begin
    w_hp_sat = w_hp[15:0];
    if (w_hp > c_hp_max) begin
      w_hp_sat = 16'sh7FFF;
    end else if (w_hp < c_hp_min) begin
      w_hp_sat = 16'sh8000;
    end
  end

  // Gain saturates at both ends so a reversal mid-ramp continues from the current value
  assign w_gain_sum = {1'b0, r_gain} + {1'b0, c_step};

  always_comb begin
    w_gain_next = r_gain;
    if (mute) begin
      w_gain_next = (r_gain > c_step) ? (r_gain - c_step) : 9'd0;
    end else begin
      w_gain_next = (w_gain_sum > 10'd256) ? 9'd256 : w_gain_sum[8:0];
    end
  end

  assign w_prod   = 25'(r_hp_sat) * $signed({16'h0000, r_gain});
  assign w_unused = &{1'b0, w_lp_sum[25:24], w_prod[24], w_prod[7:0]};

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_div     <= '0;
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_lp_acc  <= 24'h800000;
      r_dc_acc  <= {16'h8000, {DC_SHIFT{1'b0}}};
      r_hp_sat  <= '0;
      r_gain    <= 9'd256;
      audio_out <= '0;
      sample_ce <= 1'b0;
      muted     <= 1'b0;
    end else begin
      r_div     <= w_s0 ? '0 : r_div + c_div_w'(1);
      r_s1      <= w_s0;
      r_s2      <= r_s1;
      sample_ce <= r_s2;
      if (w_s0) begin
        r_lp_acc <= w_lp_sum[23:0];
      end
      if (r_s1) begin
        r_hp_sat <= w_hp_sat;
        r_dc_acc <= r_dc_acc + c_dc_w'(w_lp) - c_dc_w'(w_dc_old);
      end
      if (r_s2) begin
        audio_out <= w_prod[23:8];
        r_gain    <= w_gain_next;
        muted     <= (w_gain_next == 9'd0);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_audio_conditioner.sv
`default_nettype none
// Testbench for audio_conditioner: first-sample vector table plus a per-sample
// reference model feeding a scoreboard queue, on two parameterisations.
module tb_audio_conditioner;

  localparam int c_div_a = 8;
  localparam int c_div_b = 6;

  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  logic [1:0]       rst;
  logic [1:0][15:0] ain;
  logic [1:0]       mte;
  wire  [1:0][15:0] aout;
  wire  [1:0]       ce;
  wire  [1:0]       mtd;

  audio_conditioner #(.CE_DIV(c_div_a), .LP_SHIFT(3), .DC_SHIFT(6), .RAMP_STEP(1)) dut_a (
    .clk_sys(clk_sys), .reset(rst[0]), .audio_in(ain[0]), .mute(mte[0]),
    .audio_out(aout[0]), .sample_ce(ce[0]), .muted(mtd[0]));

  audio_conditioner #(.CE_DIV(c_div_b), .LP_SHIFT(0), .DC_SHIFT(4), .RAMP_STEP(16)) dut_b (
    .clk_sys(clk_sys), .reset(rst[1]), .audio_in(ain[1]), .mute(mte[1]),
    .audio_out(aout[1]), .sample_ce(ce[1]), .muted(mtd[1]));

  typedef struct {
    int out;
    bit muted;
  } exp_t;

  typedef struct {
    logic [15:0] x;
    bit          m;
    int          exp_out;
    bit          exp_muted;
  } vec_t;

  exp_t   sb[$];
  int     m_lp[2];
  longint m_dc[2];
  int     m_gain[2];
  int     n_chk;
  int     n_pass;

  function automatic int lp_sh(input int i);   return (i == 0) ? 3 : 0;             endfunction
  function automatic int dc_sh(input int i);   return (i == 0) ? 6 : 4;             endfunction
  function automatic int rstep(input int i);   return (i == 0) ? 1 : 16;            endfunction
  function automatic int cediv(input int i);   return (i == 0) ? c_div_a : c_div_b; endfunction

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  task automatic model_reset(input int i);
    m_lp[i]   = 32'h800000;
    m_dc[i]   = longint'(32'h8000) << dc_sh(i);
    m_gain[i] = 256;
    sb.delete();
  endtask

  task automatic model_push(input int i, input int x, input bit m);
    int   diff, lp, dcold, hp;
    exp_t e;
    diff    = x * 256 - m_lp[i];
    m_lp[i] = m_lp[i] + (diff >>> lp_sh(i));
    lp      = m_lp[i] / 256;
    dcold   = int'(m_dc[i] >>> dc_sh(i));
    hp      = lp - dcold;
    m_dc[i] = m_dc[i] + lp - dcold;
    if (hp > 32767) hp = 32767;
    else if (hp < -32768) hp = -32768;
    e.out = (hp * m_gain[i]) >>> 8;
    if (m) m_gain[i] = (m_gain[i] > rstep(i)) ? m_gain[i] - rstep(i) : 0;
    else   m_gain[i] = (m_gain[i] + rstep(i) > 256) ? 256 : m_gain[i] + rstep(i);
    e.muted = (m_gain[i] == 0);
    sb.push_back(e);
  endtask

  task automatic do_reset(input int i);
    rst[i] = 1'b1;
    ain[i] = 16'h8000;
    mte[i] = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    check("reset audio_out", int'(aout[i]), 0);
    check("reset muted", int'(mtd[i]), 0);
    check("reset sample_ce", int'(ce[i]), 0);
    rst[i] = 1'b0;
    model_reset(i);
  endtask

  // Drive one sample's inputs right after a strobe and compare at the next strobe
  task automatic run_sample(input int i, input int x, input bit m, input string name,
                            output int n, output int out, output bit mu);
    exp_t        e;
    bit          ok;
    bit          changed;
    logic [15:0] held;
    ain[i] = 16'(x);
    mte[i] = m;
    model_push(i, x, m);
    held = aout[i];
    changed = 1'b0;
    ok = 1'b0;
    n = 0;
    while (!ok && n <= 4 * cediv(i) + 4) begin
      @(posedge clk_sys);
      #1;
      n++;
      if (ce[i]) ok = 1'b1;
      else if (aout[i] !== held) changed = 1'b1;
    end
    out = int'($signed(aout[i]));
    mu  = mtd[i];
    e   = sb.pop_front();
    if (!ok) begin
      check({name, " strobe timeout"}, 0, 1);
      return;
    end
    check({name, " hold"}, int'(changed), 0);
    check({name, " out"}, out, e.out);
    check({name, " muted"}, int'(mu), int'(e.muted));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs[5];
    int   n, out, peak, x;
    bit   mu;

    vecs[0] = '{16'h8000, 1'b0, 0,     1'b0};
    vecs[1] = '{16'hC000, 1'b0, 2048,  1'b0};
    vecs[2] = '{16'h4000, 1'b0, -2048, 1'b0};
    vecs[3] = '{16'hFFFF, 1'b1, 4095,  1'b0};
    vecs[4] = '{16'h0000, 1'b0, -4096, 1'b0};

    n_chk  = 0;
    n_pass = 0;
    rst    = 2'b11;
    ain    = {16'h8000, 16'h8000};
    mte    = 2'b00;

    for (int v = 0; v < 5; v++) begin
      do_reset(0);
      run_sample(0, int'(vecs[v].x), vecs[v].m, "vec", n, out, mu);
      check("vec first strobe", n, c_div_a + 2);
      check("vec table out", out, vecs[v].exp_out);
      check("vec table muted", int'(mu), int'(vecs[v].exp_muted));
    end

    // Silence: 10000 cycles of midscale
    do_reset(0);
    for (int k = 0; k < 1250; k++) begin
      run_sample(0, 32'h8000, 1'b0, "silence", n, out, mu);
      if (k > 0) check("silence period", n, c_div_a);
      check("silence zero", out, 0);
    end

    // Step response
    do_reset(0);
    peak = 0;
    for (int k = 0; k < 1500; k++) begin
      run_sample(0, 32'hC000, 1'b0, "step", n, out, mu);
      if (out > peak) peak = out;
    end
    check("step peak above 8000", int'(peak > 8000), 1);
    check("step settled", int'(out <= 2 && out >= -2), 1);

    // Mute ramp on a square wave
    do_reset(0);
    for (int k = 0; k < 257; k++) begin
      x = ((k / 50) % 2 == 1) ? 32'h4000 : 32'hC000;
      run_sample(0, x, 1'b1, "mute", n, out, mu);
      if (k == 255) check("mute muted at 256", int'(mu), 1);
    end
    check("mute silent", out, 0);
    check("mute muted", int'(mu), 1);
    for (int k = 257; k < 513; k++) begin
      x = ((k / 50) % 2 == 1) ? 32'h4000 : 32'hC000;
      run_sample(0, x, 1'b0, "unmute", n, out, mu);
      if (k == 257) check("unmute muted falls", int'(mu), 0);
    end

    // Reset with gain at 100 and a sample in flight
    do_reset(0);
    for (int k = 0; k < 156; k++) run_sample(0, 32'hC000, 1'b1, "pre-reset", n, out, mu);
    repeat (c_div_a - 2) @(posedge clk_sys);
    #1;
    rst[0] = 1'b1;
    @(posedge clk_sys);
    #1;
    check("midreset audio_out", int'(aout[0]), 0);
    check("midreset muted", int'(mtd[0]), 0);
    check("midreset sample_ce", int'(ce[0]), 0);
    rst[0] = 1'b0;
    model_reset(0);
    run_sample(0, 32'hC000, 1'b0, "post-reset", n, out, mu);
    check("post-reset first strobe", n, c_div_a + 2);
    check("post-reset full gain", out, 2048);

    // Saturation with LP_SHIFT=0
    do_reset(1);
    for (int k = 0; k < 300; k++) begin
      run_sample(1, 32'h0000, 1'b0, "sat low", n, out, mu);
      if (k == 0) check("sat first strobe", n, c_div_b + 2);
    end
    run_sample(1, 32'hFFFF, 1'b0, "sat up", n, out, mu);
    check("sat positive clip", out, 32767);
    for (int k = 0; k < 300; k++) run_sample(1, 32'hFFFF, 1'b0, "sat high", n, out, mu);
    run_sample(1, 32'h0000, 1'b0, "sat down", n, out, mu);
    check("sat negative clip", out, -32768);

    // Ramp reversal with RAMP_STEP=16
    do_reset(1);
    for (int k = 0; k < 40; k++) begin
      x = (k % 2 == 1) ? 32'h0000 : 32'hFFFF;
      run_sample(1, x, ((k / 5) % 2) == 0, "reverse", n, out, mu);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
